// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between pipeline writeback and a queued long-latency unit.
// Optional same-cycle LU bypass on an idle, empty write port: define WB_ARB_BYPASS_EN.
`default_nettype none

module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_wreg,
  input  logic [AW-1:0] pipe_waddr,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_waddr,
  input  logic [DW-1:0] lu_wdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          bubble_req,
  output logic          lu_pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             bubble_q, bubble_d;

  logic pa, empty, pop, push, byp;

  assign pa         = pipe_wreg && (pipe_waddr != '0);
  assign empty      = (count_q == '0);
  assign lu_ready   = (count_q != (PW+1)'(DEPTH));
  assign lu_pending = !empty;
  assign bubble_req = bubble_q;
  assign pop        = !pa && !empty;

`ifdef WB_ARB_BYPASS_EN
  assign byp = !pa && empty && lu_valid;
`else
  assign byp = 1'b0;
`endif

  // r0 results complete the handshake but are dropped; bypassed results never enter the queue.
  assign push = lu_valid && lu_ready && (lu_waddr != '0) && !byp;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = pipe_waddr;
    rf_wdata = pipe_wdata;
    if (!rst) begin
      rf_we = 1'b0;
    end else if (pa) begin
      rf_we = 1'b1;
    end else if (!empty) begin
      rf_we    = vld_q[rptr_q];
      rf_waddr = addr_q[rptr_q];
      rf_wdata = data_q[rptr_q];
    end else if (byp) begin
      rf_we    = (lu_waddr != '0);
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
    end
  end

  // Kill before push: an entry enqueued alongside a matching pipe write holds the newer value.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (pa && vld_q[i] && (addr_q[i] == pipe_waddr)) vld_d[i] = 1'b0;
    end
    if (pop)  vld_d[rptr_q] = 1'b0;
    if (push) vld_d[wptr_q] = 1'b1;
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    starve_d = starve_q;
    if (empty || pop)                                starve_d = '0;
    else if (pa && (starve_q != SW'(STARVE_MAX)))    starve_d = starve_q + SW'(1);
    bubble_d = bubble_q;
    if (empty || pop)                                bubble_d = 1'b0;
    else if (starve_d == SW'(STARVE_MAX))            bubble_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      bubble_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      bubble_q <= bubble_d;
    end
  end

  // Payload needs no reset; the valid bits and count qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= lu_waddr;
      data_q[wptr_q] <= lu_wdata;
    end
  end

endmodule

`default_nettype wire
